// File: rtl/rom_fetch_queue.sv
// Instruction fetch unit: walks IP through program ROM and buffers {addr, word} in a DEPTH-entry queue.
// Optional grant-wait timeout with sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module rom_fetch_queue #(
    parameter int unsigned DATA_W  = 14,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pause_READ,
    input  logic                     jump,
    input  logic [ADDR_W-1:0]        jump_addr,
    output logic                     rom_rd,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic                     rom_rd_garant,
    input  logic [DATA_W-1:0]        rom_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [DATA_W-1:0]        cmd_data,
    output logic [ADDR_W-1:0]        cmd_addr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     fetch_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    generate
        if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
            TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
            $error("rom_fetch_queue: illegal DEPTH or TIMEOUT");
        end
    endgenerate

    logic [0:0]        state;
    logic [ADDR_W-1:0] ip;
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              pop;
    logic              grant;
    logic              push;
    logic              issue;
    logic              timeout;
    logic [LVL_W-1:0]  level_next;

    assign cmd_valid  = (level != '0);
    assign pop        = cmd_valid && cmd_ready;
    assign grant      = (state == REQ) && rom_rd_garant;
    assign push       = grant && !jump;
    // Occupancy after this edge; a new request is issued only if a slot stays free for its data.
    assign level_next = level - LVL_W'(pop) + LVL_W'(push);
    assign issue      = !pause_READ && !jump && (level_next < LVL_W'(DEPTH));
    assign cmd_data   = q_data[rd_ptr];
    assign cmd_addr   = q_addr[rd_ptr];

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Fires on the TIMEOUT-th ungranted cycle, so rom_rd stays high for TIMEOUT cycles.
    assign timeout = (state == REQ) && !rom_rd_garant && (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else if (jump) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else if (state == REQ && !rom_rd_garant) begin
            if (timeout) begin
                wait_cnt  <= '0;
                fetch_err <= 1'b1;
            end else begin
                wait_cnt  <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rom_rd   <= 1'b0;
            rom_addr <= '0;
            ip       <= '0;
            level    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (jump) begin
            state  <= IDLE;
            rom_rd <= 1'b0;
            ip     <= jump_addr;
            level  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            level <= level_next;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state    <= REQ;
                        rom_rd   <= 1'b1;
                        rom_addr <= ip;
                    end
                end
                REQ: begin
                    if (grant) begin
                        ip <= ip + 1'b1;
                        if (issue) begin
                            rom_addr <= ip + 1'b1;
                        end else begin
                            state  <= IDLE;
                            rom_rd <= 1'b0;
                        end
                    end else if (timeout) begin
                        state  <= IDLE;
                        rom_rd <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rom_rd <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= rom_data;
            q_addr[wr_ptr] <= ip;
        end
    end

endmodule

// File: tb/tb_rom_fetch_queue.sv
// Directed bench for rom_fetch_queue; the timeout vectors run only when FETCH_TIMEOUT_EN is defined.
module tb_rom_fetch_queue;

    localparam int unsigned DATA_W  = 14;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              pause_READ;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd_garant;
    logic [DATA_W-1:0] rom_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic [ADDR_W-1:0] cmd_addr;
    logic [$clog2(DEPTH):0] level;
    logic              fetch_err;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    rom_fetch_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pause_READ   (pause_READ),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .rom_rd       (rom_rd),
        .rom_addr     (rom_addr),
        .rom_rd_garant(rom_rd_garant),
        .rom_data     (rom_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_addr     (cmd_addr),
        .level        (level),
        .fetch_err    (fetch_err)
    );

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return {2'b10, a ^ 12'h5A5};
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n       = 1'b0;
        pause_READ    = 1'b0;
        jump          = 1'b0;
        jump_addr     = '0;
        rom_rd_garant = 1'b0;
        cmd_ready     = 1'b0;
        repeat (2) tick;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset;
        check("rst_rom_rd", rom_rd, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_level", level, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_fetch_err", fetch_err, 0);

        // sequential fill
        rom_rd_garant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("fill_rom_rd", rom_rd, 1);
            check("fill_rom_addr", rom_addr, k);
        end
        tick;
        check("fill_rd_fall", rom_rd, 0);
        check("fill_level", level, 4);
        check("fill_cmd_valid", cmd_valid, 1);
        check("fill_cmd_addr", cmd_addr, 0);
        check("fill_cmd_data", cmd_data, rom_word(12'h000));
        tick;
        check("fill_rd_stay", rom_rd, 0);
        check("fill_level_stay", level, 4);

        // streaming
        do_reset;
        rom_rd_garant = 1'b1;
        cmd_ready     = 1'b1;
        tick;
        check("strm_first_valid", cmd_valid, 0);
        for (int k = 0; k < 10; k++) begin
            tick;
            check("strm_valid", cmd_valid, 1);
            check("strm_cmd_addr", cmd_addr, k);
            check("strm_cmd_data", cmd_data, rom_word(ADDR_W'(k)));
            check("strm_level", level, 1);
        end

        // asynchronous reset drops rom_rd before the next edge
        check("async_pre_rd", rom_rd, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_rd", rom_rd, 0);
        check("async_rst_level", level, 0);

        // jump while a request at address 5 is waiting
        do_reset;
        rom_rd_garant = 1'b1;
        cmd_ready     = 1'b1;
        repeat (6) tick;
        check("jmp_pre_addr", rom_addr, 5);
        rom_rd_garant = 1'b0;
        cmd_ready     = 1'b0;
        tick;
        check("jmp_hold_rd", rom_rd, 1);
        check("jmp_hold_addr", rom_addr, 5);
        check("jmp_hold_level", level, 1);
        jump      = 1'b1;
        jump_addr = 12'h3F0;
        tick;
        jump = 1'b0;
        check("jmp_level", level, 0);
        check("jmp_rd", rom_rd, 0);
        check("jmp_valid", cmd_valid, 0);
        tick;
        check("jmp_req_rd", rom_rd, 1);
        check("jmp_req_addr", rom_addr, 12'h3F0);
        rom_rd_garant = 1'b1;
        tick;
        check("jmp_head_valid", cmd_valid, 1);
        check("jmp_head_addr", cmd_addr, 12'h3F0);
        check("jmp_head_data", cmd_data, rom_word(12'h3F0));

        // jump coinciding with grant and pop
        do_reset;
        rom_rd_garant = 1'b1;
        repeat (3) tick;
        check("jg_pre_level", level, 2);
        check("jg_pre_addr", rom_addr, 2);
        cmd_ready = 1'b1;
        jump      = 1'b1;
        jump_addr = 12'h123;
        tick;
        jump          = 1'b0;
        cmd_ready     = 1'b0;
        rom_rd_garant = 1'b0;
        check("jg_level", level, 0);
        check("jg_valid", cmd_valid, 0);
        check("jg_rd", rom_rd, 0);
        tick;
        check("jg_ip_addr", rom_addr, 12'h123);
        rom_rd_garant = 1'b1;
        tick;
        check("jg_head_addr", cmd_addr, 12'h123);
        check("jg_head_level", level, 1);

        // wrap from 0xFFF to 0x000
        jump      = 1'b1;
        jump_addr = 12'hFFF;
        cmd_ready = 1'b1;
        tick;
        jump = 1'b0;
        check("wrap_jmp_rd", rom_rd, 0);
        tick;
        check("wrap_addr_fff", rom_addr, 12'hFFF);
        tick;
        check("wrap_head_fff", cmd_addr, 12'hFFF);
        check("wrap_addr_000", rom_addr, 12'h000);
        tick;
        check("wrap_head_000", cmd_addr, 12'h000);
        check("wrap_addr_001", rom_addr, 12'h001);

        // pause with a request outstanding
        pause_READ    = 1'b1;
        rom_rd_garant = 1'b0;
        cmd_ready     = 1'b0;
        tick;
        check("pause_hold_rd", rom_rd, 1);
        check("pause_hold_addr", rom_addr, 12'h001);
        rom_rd_garant = 1'b1;
        tick;
        check("pause_done_rd", rom_rd, 0);
        check("pause_level", level, 2);
        tick;
        check("pause_idle_rd", rom_rd, 0);
        pause_READ = 1'b0;
        tick;
        check("pause_resume_rd", rom_rd, 1);
        check("pause_resume_addr", rom_addr, 12'h002);

`ifdef FETCH_TIMEOUT_EN
        do_reset;
        tick;
        check("to_req_rd", rom_rd, 1);
        repeat (TIMEOUT - 1) tick;
        check("to_last_rd", rom_rd, 1);
        check("to_err_low", fetch_err, 0);
        tick;
        check("to_fall_rd", rom_rd, 0);
        check("to_err", fetch_err, 1);
        tick;
        check("to_retry_rd", rom_rd, 1);
        check("to_retry_addr", rom_addr, 0);
        check("to_err_sticky", fetch_err, 1);
        jump      = 1'b1;
        jump_addr = 12'h040;
        tick;
        jump = 1'b0;
        check("to_err_clear", fetch_err, 0);
`else
        check("no_to_err", fetch_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
